// File: rtl/iter_divider_pkg.sv
// Shared encodings for the iterative divider: FSM states, handshake levels
// and the all-zero data word.
package iter_divider_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_t;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

endpackage

// File: rtl/iter_divider_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem,
  input  logic              dividend_bit,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic              quo_bit
);

  logic [DATA_W:0]   shifted;
  logic [DATA_W-1:0] diff;

  assign shifted = {rem, dividend_bit};
  assign quo_bit = (shifted >= {1'b0, divisor});
  // The remainder stays below the divisor, so a successful subtraction
  // always fits back into DATA_W bits.
  assign diff     = shifted[DATA_W-1:0] - divisor;
  assign rem_next = quo_bit ? diff : shifted[DATA_W-1:0];

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider with start/annul request handshake;
// produces {remainder, quotient} after DATA_W iterations.
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                busy_o
);

  div_state_t state;

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] quo_reg;
  logic [DATA_W-1:0] rem_reg;
  logic [DATA_W-1:0] divisor_reg;
  logic              signed_reg;
  logic              sign_a_reg;
  logic              sign_b_reg;

  logic [DATA_W-1:0] mag_a;
  logic [DATA_W-1:0] mag_b;
  logic [DATA_W-1:0] step_rem;
  logic              step_bit;
  logic [DATA_W-1:0] quo_next;
  logic [DATA_W-1:0] quo_fix;
  logic [DATA_W-1:0] rem_fix;

  assign mag_a = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign mag_b = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  // The dividend register doubles as the quotient: its MSB feeds the step
  // and the new quotient bit shifts in at the LSB.
  div_step #(.DATA_W(DATA_W)) u_step (
    .rem          (rem_reg),
    .dividend_bit (quo_reg[DATA_W-1]),
    .divisor      (divisor_reg),
    .rem_next     (step_rem),
    .quo_bit      (step_bit)
  );

  assign quo_next = {quo_reg[DATA_W-2:0], step_bit};

  // Remainder takes the dividend's sign; quotient is negative when signs differ.
  assign quo_fix = (signed_reg && (sign_a_reg ^ sign_b_reg)) ? -quo_next : quo_next;
  assign rem_fix = (signed_reg && sign_a_reg) ? -step_rem : step_rem;

  assign busy_o = (state == DivByZero) || (state == DivOn);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= DivFree;
      result_o    <= '0;
      ready_o     <= DivResultNotReady;
      cnt         <= '0;
      quo_reg     <= '0;
      rem_reg     <= '0;
      divisor_reg <= '0;
      signed_reg  <= 1'b0;
      sign_a_reg  <= 1'b0;
      sign_b_reg  <= 1'b0;
    end else begin
      case (state)
        DivFree: begin
          if (start_i == DivStart && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= DivByZero;
            end else begin
              state       <= DivOn;
              cnt         <= '0;
              quo_reg     <= mag_a;
              rem_reg     <= '0;
              divisor_reg <= mag_b;
              signed_reg  <= signed_div_i;
              sign_a_reg  <= opdata1_i[DATA_W-1];
              sign_b_reg  <= opdata2_i[DATA_W-1];
            end
          end
        end
        DivByZero: begin
          state    <= DivEnd;
          result_o <= '0;
          ready_o  <= DivResultReady;
        end
        DivOn: begin
          if (annul_i) begin
            state    <= DivFree;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
          end else begin
            rem_reg <= step_rem;
            quo_reg <= quo_next;
            cnt     <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(DATA_W - 1)) begin
              state    <= DivEnd;
              result_o <= {rem_fix, quo_fix};
              ready_o  <= DivResultReady;
            end
          end
        end
        DivEnd: begin
          if (start_i == DivStop) begin
            state    <= DivFree;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
          end
        end
        default: state <= DivFree;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Directed self-checking bench for iter_divider: latency, signed/unsigned
// results, divide-by-zero, annul, reset aborts and operand isolation.
module tb_iter_divider;
  import iter_divider_pkg::*;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        busy;

  int checks;
  int errors;

  iter_divider #(.DATA_W(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (opdata1),
    .opdata2_i    (opdata2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise start and count edges (E0 included) until ready; 0 means timeout.
  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [63:0] res);
    signed_div = s;
    opdata1    = a;
    opdata2    = b;
    start      = DivStart;
    lat        = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (ready) begin
        lat = i;
        break;
      end
    end
    res = result;
  endtask

  task automatic drop_start();
    start = DivStop;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
    checks++;
    if (result !== 64'd0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    tick();
    $display("reset done: ready=%b busy=%b result=%h", ready, busy, result);
  endtask

  task automatic test_unsigned();
    int lat;
    logic [63:0] res;
    run_div(1'b0, 32'd100, 32'd7, lat, res);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL u100_7_latency: got %0d want 33", lat); end
    checks++;
    if (res !== 64'h00000002_0000000E) begin errors++; $display("FAIL u100_7_result: got %h want 000000020000000e", res); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL u100_7_busy_end: got %b want 0", busy); end
    tick();
    tick();
    checks++;
    if (ready !== 1'b1 || result !== 64'h00000002_0000000E) begin
      errors++; $display("FAIL u100_7_hold: got ready=%b result=%h want 1 000000020000000e", ready, result);
    end
    drop_start();
    checks++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      errors++; $display("FAIL u100_7_release: got ready=%b result=%h want 0 0", ready, result);
    end
    $display("unsigned 100/7: latency=%0d result=%h", lat, res);
    tick();
  endtask

  task automatic test_signed();
    int lat;
    logic [63:0] res;
    run_div(1'b1, 32'hFFFFFFF9, 32'h00000002, lat, res);
    checks++;
    if (lat !== 33 || res !== 64'hFFFFFFFF_FFFFFFFD) begin
      errors++; $display("FAIL s_m7_2: got lat=%0d result=%h want 33 fffffffffffffffd", lat, res);
    end
    $display("signed -7/2: latency=%0d result=%h", lat, res);
    drop_start();
    run_div(1'b1, 32'h00000007, 32'hFFFFFFFE, lat, res);
    checks++;
    if (lat !== 33 || res !== 64'h00000001_FFFFFFFD) begin
      errors++; $display("FAIL s_7_m2: got lat=%0d result=%h want 33 00000001fffffffd", lat, res);
    end
    $display("signed 7/-2: latency=%0d result=%h", lat, res);
    drop_start();
  endtask

  task automatic test_div_zero();
    signed_div = 1'b0;
    opdata1    = 32'h12345678;
    opdata2    = 32'd0;
    start      = DivStart;
    tick();
    checks++;
    if (busy !== 1'b1 || ready !== 1'b0) begin
      errors++; $display("FAIL dz_after_e0: got busy=%b ready=%b want 1 0", busy, ready);
    end
    tick();
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || result !== 64'd0) begin
      errors++; $display("FAIL dz_after_e1: got ready=%b busy=%b result=%h want 1 0 0", ready, busy, result);
    end
    $display("divide by zero: ready=%b result=%h", ready, result);
    drop_start();
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL dz_release: got %b want 0", ready); end
  endtask

  task automatic test_overflow();
    int lat;
    logic [63:0] res;
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, lat, res);
    checks++;
    if (lat !== 33 || res !== 64'h00000000_80000000) begin
      errors++; $display("FAIL s_min_m1: got lat=%0d result=%h want 33 0000000080000000", lat, res);
    end
    $display("signed min/-1: result=%h", res);
    drop_start();
    run_div(1'b0, 32'hFFFFFFFF, 32'd1, lat, res);
    checks++;
    if (lat !== 33 || res !== 64'h00000000_FFFFFFFF) begin
      errors++; $display("FAIL u_max_1: got lat=%0d result=%h want 33 00000000ffffffff", lat, res);
    end
    $display("unsigned max/1: result=%h", res);
    drop_start();
  endtask

  task automatic test_annul();
    int lat;
    int seen;
    logic [63:0] res;
    signed_div = 1'b0;
    opdata1    = 32'd100;
    opdata2    = 32'd7;
    start      = DivStart;
    repeat (11) tick();
    start = DivStop;
    annul = 1'b1;
    tick();
    annul = 1'b0;
    checks++;
    if (busy !== 1'b0 || ready !== 1'b0 || result !== 64'd0) begin
      errors++; $display("FAIL annul_free: got busy=%b ready=%b result=%h want 0 0 0", busy, ready, result);
    end
    seen = 0;
    repeat (30) begin
      tick();
      if (ready !== 1'b0 || busy !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL annul_quiet: got %0d active cycles want 0", seen); end
    run_div(1'b0, 32'd9, 32'd3, lat, res);
    checks++;
    if (lat !== 33 || res !== 64'h00000000_00000003) begin
      errors++; $display("FAIL annul_restart: got lat=%0d result=%h want 33 0000000000000003", lat, res);
    end
    $display("annul then 9/3: latency=%0d result=%h", lat, res);
    drop_start();
  endtask

  task automatic test_reset_abort();
    int lat;
    logic [63:0] res;
    signed_div = 1'b0;
    opdata1    = 32'd1000;
    opdata2    = 32'd3;
    start      = DivStart;
    repeat (21) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || ready !== 1'b0 || result !== 64'd0) begin
      errors++; $display("FAIL rst_mid_on: got busy=%b ready=%b result=%h want 0 0 0", busy, ready, result);
    end
    rst   = 1'b0;
    start = DivStop;
    tick();
    $display("reset at iteration 20: busy=%b ready=%b", busy, ready);
    run_div(1'b0, 32'd50, 32'd5, lat, res);
    checks++;
    if (res !== 64'h00000000_0000000A) begin errors++; $display("FAIL rst_pre_end: got %h want 000000000000000a", res); end
    rst = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || ready !== 1'b0 || result !== 64'd0) begin
      errors++; $display("FAIL rst_in_end: got busy=%b ready=%b result=%h want 0 0 0", busy, ready, result);
    end
    rst   = 1'b0;
    start = DivStop;
    tick();
    $display("reset in END: busy=%b ready=%b", busy, ready);
  endtask

  task automatic test_operand_change();
    int lat;
    logic [63:0] res;
    signed_div = 1'b1;
    opdata1    = 32'hFFFFFF9C;
    opdata2    = 32'd7;
    start      = DivStart;
    tick();
    lat = 0;
    for (int i = 2; i <= 40; i++) begin
      opdata1    = $urandom;
      opdata2    = $urandom;
      signed_div = ~signed_div;
      tick();
      if (ready) begin
        lat = i;
        break;
      end
    end
    res = result;
    checks++;
    if (lat !== 33 || res !== 64'hFFFFFFFE_FFFFFFF2) begin
      errors++; $display("FAIL op_change: got lat=%0d result=%h want 33 fffffffefffffff2", lat, res);
    end
    $display("signed -100/7 with operand churn: result=%h", res);
    drop_start();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    signed_div = 1'b0;
    opdata1    = ZeroWord;
    opdata2    = ZeroWord;
    start      = DivStop;
    annul      = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_annul();
    test_reset_abort();
    test_operand_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
Multi-cycle radix-2 restoring divider that answers the execute stage's divide request handshake (start/annul in, ready/result out).
- Accepts signed or unsigned 32-bit operands and produces {remainder, quotient} after a fixed iteration count.
- Holds ready until the requester drops start, so the pipeline stall is released on exactly one cycle.
- Sits beside the execute stage; its result feeds the HI/LO write path.

Parameters:
DATA_W, 32, operand width; result is 2*DATA_W.
CNT_W, 6, iteration counter width; must hold the value DATA_W.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
signed_div_i  in  1  1 = signed divide, 0 = unsigned
opdata1_i  in  DATA_W  dividend
opdata2_i  in  DATA_W  divisor
start_i  in  1  request; held high by the requester until ready_o is seen
annul_i  in  1  abort the divide in progress
result_o  out  2*DATA_W  {remainder[63:32], quotient[31:0]}
ready_o  out  1  result valid
busy_o  out  1  state is DIV_ZERO or ON

Behaviour:
- Reset: clk and rst are as already decided (reset rst, synchronous, active-high; clock clk). On reset: state goes to FREE, result_o is 0, ready_o is 0, busy_o is 0, and the counter is 0. Reset mid-divide aborts with no ready pulse.
- States: FREE, DIV_ZERO, ON, END.
- FREE:
  - start_i=1, annul_i=0, divisor=0 → go to DIV_ZERO.
  - start_i=1, annul_i=0, divisor≠0 → go to ON. At the same edge, latch the magnitudes of both operands (two's-complement negate when signed_div_i and the MSB is set), signed_div_i, both operand sign bits, and clear the counter.
  - Any other input → stay in FREE.
- DIV_ZERO: next edge go to END with result_o=0 and ready_o=1.
- ON, one iteration per edge:
  - Shift {partial remainder, dividend} left by 1.
  - If the partial remainder is ≥ the divisor magnitude: subtract it and set the quotient LSB to 1. Otherwise set the quotient LSB to 0.
  - Increment the counter.
  - annul_i=1 in ON → go to FREE; result_o stays 0 and ready_o is never raised.
  - On the edge that completes iteration DATA_W: apply sign correction, then go to END with ready_o=1 and result_o loaded.
- Sign correction, signed mode only:
  - Quotient is negated if the dividend and divisor signs differ.
  - Remainder is negated if the dividend is negative, so the remainder sign follows the dividend.
  - Unsigned mode applies no correction.
- END:
  - Hold ready_o=1 and result_o stable while start_i=1.
  - On the first edge with start_i=0, go to FREE with ready_o=0 and result_o=0.
- Latency, nonzero divisor: start sampled at edge E0; ready_o is high in the cycle after edge E(DATA_W), i.e. the 33rd cycle after the start cycle.
- Latency, zero divisor: ready_o is high in the cycle after E1.
- Operand inputs are don't-care after E0; changes during ON are ignored.
- Overflow case -2^31 / -1 (signed): quotient 0x80000000, remainder 0. This is the natural wrap; no special handling.
- annul_i has no effect in DIV_ZERO or END.
- start_i is ignored outside FREE.
- busy_o=1 exactly in DIV_ZERO and ON.

Decomposition:
- Shared defines header holds:
  - state encodings DivFree, DivByZero, DivOn, DivEnd (2 bits);
  - DivStart/DivStop;
  - DivResultReady/DivResultNotReady;
  - ZeroWord.
- One natural sub-module, div_step: combinational single iteration. Inputs are the partial remainder, the dividend bit and the divisor. Outputs are the next partial remainder and the quotient bit. The top module owns the FSM, counter and sign fix-up.

Test Plan:
- Unsigned 100 / 7, start held → ready_o rises 33 cycles after the start cycle with result_o=0x00000002_0000000E; drop start → next cycle ready_o=0 and result_o=0.
- Signed -7 / 2 (0xFFFFFFF9, 0x00000002) → result_o=0xFFFFFFFF_FFFFFFFD; signed 7 / -2 → 0x00000001_FFFFFFFD.
- Divisor 0 with dividend 0x12345678 → busy_o for 1 cycle, ready_o in the cycle after E1, result_o=0.
- Signed 0x80000000 / 0xFFFFFFFF → result_o=0x00000000_80000000; unsigned 0xFFFFFFFF / 1 → 0x00000000_FFFFFFFF.
- Annul after 10 iterations → FREE next edge, no ready pulse. A new start of 9 / 3 then gives ready after 33 cycles with 0x00000000_00000003.
- Assert rst at iteration 20, or while in END with start held → next cycle state is FREE, ready_o=0, result_o=0, busy_o=0. Operands changed mid-ON do not alter the result.
